stage3_execute: RTL and testbench

- Execute stage of the 5-stage RISC-V pipeline. It sits directly downstream of the decode stage and consumes the ID/EX pipeline registers.
- Computes the ALU result, resolves branches, and runs RV32M mul/div as an iterative 32-step unit.
- Drives the EX/MEM pipeline registers, the branch redirect, and a stall request back to fetch/decode.

---
 rtl/stage3_execute_pkg.sv | 77 +++++++
 rtl/stage3_execute_if.sv | 40 ++++
 rtl/stage3_execute_muldiv_iter.sv | 139 +++++++++++++
 rtl/stage3_execute.sv | 129 ++++++++++++
 tb/tb_stage3_execute.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stage3_execute_pkg.sv
// Shared definitions for the execute stage: ALU/branch/mul-div encodings,
// the mul/div FSM state type and the EX/MEM register bundle.
package stage3_execute_pkg;

    localparam int XLEN     = 32;
    localparam int MD_STEPS = 32;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_BRANCH = 2'b01,
        ALU_RTYPE  = 2'b10,
        ALU_ITYPE  = 2'b11
    } aluop_t;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_BUSY = 2'b01,
        MD_DONE = 2'b10
    } md_state_t;

    typedef struct packed {
        logic [XLEN-1:0] aluResult;
        logic [XLEN-1:0] data2;
        logic [4:0]      rd;
        logic [2:0]      func3;
        logic [1:0]      memCtrl;
        logic [1:0]      wbCtrl;
    } exmem_t;

    // Undefined func3 codes never take the branch.
    function automatic logic branchCompare(input logic [2:0] f3,
                                           input logic [XLEN-1:0] a,
                                           input logic [XLEN-1:0] b);
        logic result;
        result = 1'b0;
        case (f3)
            F3_BEQ:  result = (a == b);
            F3_BNE:  result = (a != b);
            F3_BLT:  result = ($signed(a) <  $signed(b));
            F3_BGE:  result = ($signed(a) >= $signed(b));
            F3_BLTU: result = (a <  b);
            F3_BGEU: result = (a >= b);
            default: result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/stage3_execute_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage, bundled as one port.
interface stage3_execute_if;
    import stage3_execute_pkg::*;

    logic [XLEN-1:0] idexPc;
    logic [XLEN-1:0] idexData1;
    logic [XLEN-1:0] idexData2;
    logic [4:0]      idexRd;
    logic [6:0]      idexFunc7;
    logic [2:0]      idexFunc3;
    logic [63:0]     idexExpandInst;
    logic [2:0]      idexExCtrl;
    logic [2:0]      idexMemCtrl;
    logic [1:0]      idexWbCtrl;

    logic [XLEN-1:0] exmemAluResult;
    logic [XLEN-1:0] exmemData2;
    logic [4:0]      exmemRd;
    logic [2:0]      exmemFunc3;
    logic [1:0]      exmemMemCtrl;
    logic [1:0]      exmemWbCtrl;
    logic            exBranchTaken;
    logic [XLEN-1:0] exBranchTarget;
    logic            exBusy;

    modport master (
        output idexPc, idexData1, idexData2, idexRd, idexFunc7, idexFunc3,
               idexExpandInst, idexExCtrl, idexMemCtrl, idexWbCtrl,
        input  exmemAluResult, exmemData2, exmemRd, exmemFunc3, exmemMemCtrl,
               exmemWbCtrl, exBranchTaken, exBranchTarget, exBusy
    );

    modport slave (
        input  idexPc, idexData1, idexData2, idexRd, idexFunc7, idexFunc3,
               idexExpandInst, idexExCtrl, idexMemCtrl, idexWbCtrl,
        output exmemAluResult, exmemData2, exmemRd, exmemFunc3, exmemMemCtrl,
               exmemWbCtrl, exBranchTaken, exBranchTarget, exBusy
    );

endinterface

// File: rtl/stage3_execute_muldiv_iter.sv
// Iterative RV32M unit: one shift-add (mul) or restoring-subtract (div) step
// per cycle on operand magnitudes, with the sign applied to the final value.
module muldiv_iter
    import stage3_execute_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    md_state_t       r_state;
    md_state_t       w_nextState;
    logic [4:0]      r_count;
    logic [2:0]      r_op;
    logic            r_negRes;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_b;

    logic            w_aSigned;
    logic            w_bSigned;
    logic            w_negA;
    logic            w_negB;
    logic            w_negRes;
    logic [XLEN-1:0] w_magA;
    logic [XLEN-1:0] w_magB;
    logic [XLEN:0]   w_mulSum;
    logic [XLEN:0]   w_divShift;
    logic            w_divFits;
    logic [XLEN-1:0] w_divDiff;
    logic [2*XLEN-1:0] w_product;
    logic [XLEN-1:0] w_quotient;
    logic [XLEN-1:0] w_remainder;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= MD_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            MD_IDLE: if (i_start) w_nextState = MD_BUSY;
            MD_BUSY: if (r_count == 5'(MD_STEPS - 1)) w_nextState = MD_DONE;
            MD_DONE: w_nextState = MD_IDLE;
            default: w_nextState = MD_IDLE;
        endcase
    end

    always_comb begin
        o_busy = (r_state == MD_BUSY);
        o_done = (r_state == MD_DONE);
    end

    assign w_aSigned = (i_op == F3_MULH) || (i_op == F3_MULHSU) ||
                       (i_op == F3_DIV)  || (i_op == F3_REM);
    assign w_bSigned = (i_op == F3_MULH) || (i_op == F3_DIV) || (i_op == F3_REM);
    assign w_negA    = w_aSigned & i_a[XLEN-1];
    assign w_negB    = w_bSigned & i_b[XLEN-1];
    assign w_magA    = w_negA ? -i_a : i_a;
    assign w_magB    = w_negB ? -i_b : i_b;

    // Quotient keeps a positive sign on divide-by-zero so it reads as all ones.
    always_comb begin
        w_negRes = 1'b0;
        case (i_op)
            F3_MULH, F3_MULHSU: w_negRes = w_negA ^ w_negB;
            F3_DIV:             w_negRes = (w_negA ^ w_negB) && (i_b != '0);
            F3_REM:             w_negRes = w_negA;
            default:            w_negRes = 1'b0;
        endcase
    end

    assign w_mulSum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    assign w_divShift = {r_hi, r_lo[XLEN-1]};
    assign w_divFits  = (w_divShift >= {1'b0, r_b});
    assign w_divDiff  = w_divShift[XLEN-1:0] - r_b;

    // Both operations keep a in r_lo and b in r_b; r_hi is the running
    // partial product or partial remainder.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_op     <= '0;
            r_negRes <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    if (i_start) begin
                        r_count  <= '0;
                        r_op     <= i_op;
                        r_negRes <= w_negRes;
                        r_hi     <= '0;
                        r_lo     <= w_magA;
                        r_b      <= w_magB;
                    end
                end
                MD_BUSY: begin
                    r_count <= r_count + 5'd1;
                    if (r_op[2]) begin
                        r_hi <= w_divFits ? w_divDiff : w_divShift[XLEN-1:0];
                        r_lo <= {r_lo[XLEN-2:0], w_divFits};
                    end else begin
                        r_hi <= w_mulSum[XLEN:1];
                        r_lo <= {w_mulSum[0], r_lo[XLEN-1:1]};
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_product   = r_negRes ? -{r_hi, r_lo} : {r_hi, r_lo};
    assign w_quotient  = r_negRes ? -r_lo : r_lo;
    assign w_remainder = r_negRes ? -r_hi : r_hi;

    always_comb begin
        o_result = '0;
        case (r_op)
            F3_MUL:                       o_result = w_product[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: o_result = w_product[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              o_result = w_quotient;
            default:                      o_result = w_remainder;
        endcase
    end

endmodule

// File: rtl/stage3_execute.sv
// Execute stage: single-cycle ALU and branch resolution, iterative mul/div,
// EX/MEM register, branch redirect and upstream stall request.
module stage3_execute
    import stage3_execute_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    stage3_execute_if.slave exBus
);

    exmem_t          r_exmem;
    exmem_t          w_exmemNext;
    logic            r_branchTaken;
    logic [XLEN-1:0] r_branchTarget;

    aluop_t          w_aluOp;
    logic            w_aluSrc;
    logic [XLEN-1:0] w_imm;
    logic            w_unusedImmHigh;
    logic [XLEN-1:0] w_opB;
    logic [4:0]      w_shamt;
    logic [XLEN-1:0] w_aluResult;
    logic            w_isBubble;
    logic            w_isMulDiv;
    logic            w_taken;
    logic            w_mStart;
    logic            w_mdBusy;
    logic            w_mdDone;
    logic [XLEN-1:0] w_mdResult;
    logic            w_dropInst;

    assign w_aluOp         = aluop_t'(exBus.idexExCtrl[2:1]);
    assign w_aluSrc        = exBus.idexExCtrl[0];
    assign w_imm           = exBus.idexExpandInst[XLEN-1:0];
    assign w_unusedImmHigh = ^exBus.idexExpandInst[63:XLEN];
    assign w_opB           = w_aluSrc ? w_imm : exBus.idexData2;
    assign w_shamt         = w_opB[4:0];

    assign w_isBubble = (exBus.idexExCtrl == '0) && (exBus.idexMemCtrl == '0) &&
                        (exBus.idexWbCtrl == '0);
    assign w_isMulDiv = (w_aluOp == ALU_RTYPE) && (exBus.idexFunc7 == F7_MULDIV);

    // While a redirect is leaving EX, the instruction behind it is wrong-path.
    assign w_taken  = exBus.idexMemCtrl[2] && !r_branchTaken &&
                      branchCompare(exBus.idexFunc3, exBus.idexData1, exBus.idexData2);
    assign w_mStart = w_isMulDiv && !r_branchTaken && !w_mdBusy && !w_mdDone;

    always_comb begin
        w_aluResult = '0;
        case (w_aluOp)
            ALU_ADD:    w_aluResult = exBus.idexData1 + w_opB;
            ALU_BRANCH: w_aluResult = '0;
            default: begin
                case (exBus.idexFunc3)
                    F3_ADD: begin
                        if (w_aluOp == ALU_RTYPE && exBus.idexFunc7 == F7_ALT)
                            w_aluResult = exBus.idexData1 - w_opB;
                        else
                            w_aluResult = exBus.idexData1 + w_opB;
                    end
                    F3_SLL:  w_aluResult = exBus.idexData1 << w_shamt;
                    F3_SLT:  w_aluResult = {31'b0, $signed(exBus.idexData1) < $signed(w_opB)};
                    F3_SLTU: w_aluResult = {31'b0, exBus.idexData1 < w_opB};
                    F3_XOR:  w_aluResult = exBus.idexData1 ^ w_opB;
                    F3_SR: begin
                        if ((w_aluOp == ALU_RTYPE) ? (exBus.idexFunc7 == F7_ALT) : w_imm[10])
                            w_aluResult = $signed(exBus.idexData1) >>> w_shamt;
                        else
                            w_aluResult = exBus.idexData1 >> w_shamt;
                    end
                    F3_OR:   w_aluResult = exBus.idexData1 | w_opB;
                    default: w_aluResult = exBus.idexData1 & w_opB;
                endcase
            end
        endcase
    end

    muldiv_iter u_muldiv (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_mStart),
        .i_op     (exBus.idexFunc3),
        .i_a      (exBus.idexData1),
        .i_b      (exBus.idexData2),
        .o_busy   (w_mdBusy),
        .o_done   (w_mdDone),
        .o_result (w_mdResult)
    );

    // The held M-op is retired from DONE; any other stalled or dropped slot is a bubble.
    assign w_dropInst = r_branchTaken | w_isBubble | w_taken | w_isMulDiv | w_mdBusy;

    always_comb begin
        w_exmemNext = '0;
        if (w_mdDone || !w_dropInst) begin
            w_exmemNext.aluResult = w_mdDone ? w_mdResult : w_aluResult;
            w_exmemNext.data2     = exBus.idexData2;
            w_exmemNext.rd        = exBus.idexRd;
            w_exmemNext.func3     = exBus.idexFunc3;
            w_exmemNext.memCtrl   = exBus.idexMemCtrl[1:0];
            w_exmemNext.wbCtrl    = exBus.idexWbCtrl;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_exmem        <= '0;
            r_branchTaken  <= 1'b0;
            r_branchTarget <= '0;
        end else begin
            r_exmem       <= w_exmemNext;
            r_branchTaken <= w_taken;
            if (w_taken) begin
                r_branchTarget <= exBus.idexPc + w_imm;
            end
        end
    end

    assign exBus.exmemAluResult = r_exmem.aluResult;
    assign exBus.exmemData2     = r_exmem.data2;
    assign exBus.exmemRd        = r_exmem.rd;
    assign exBus.exmemFunc3     = r_exmem.func3;
    assign exBus.exmemMemCtrl   = r_exmem.memCtrl;
    assign exBus.exmemWbCtrl    = r_exmem.wbCtrl;
    assign exBus.exBranchTaken  = r_branchTaken;
    assign exBus.exBranchTarget = r_branchTarget;
    assign exBus.exBusy         = rst_n & (w_mStart | w_mdBusy);

endmodule

// File: tb/tb_stage3_execute.sv
// Self-checking bench for stage3_execute: directed cases plus randomized
// ALU/branch and mul/div traffic compared against an arithmetic reference model.
module tb_stage3_execute;
    import stage3_execute_pkg::*;

    logic clk;
    logic rst_n;
    int   compared   = 0;
    int   mismatched = 0;
    logic expPrevTaken;

    stage3_execute_if exBus ();

    stage3_execute dut (
        .clk   (clk),
        .rst_n (rst_n),
        .exBus (exBus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%08h expected=%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] d1,
                                 input logic [31:0] d2, input logic [4:0] rd,
                                 input logic [6:0] f7, input logic [2:0] f3,
                                 input logic [31:0] imm, input logic [2:0] exc,
                                 input logic [2:0] memc, input logic [1:0] wbc);
        exBus.idexPc         = pc;
        exBus.idexData1      = d1;
        exBus.idexData2      = d2;
        exBus.idexRd         = rd;
        exBus.idexFunc7      = f7;
        exBus.idexFunc3      = f3;
        exBus.idexExpandInst = {{32{imm[31]}}, imm};
        exBus.idexExCtrl     = exc;
        exBus.idexMemCtrl    = memc;
        exBus.idexWbCtrl     = wbc;
        #1;
    endtask

    task automatic applyBubble();
        applyStimulus(32'h0, 32'h0, 32'h0, 5'd0, 7'd0, 3'd0, 32'h0, 3'd0, 3'd0, 2'd0);
    endtask

    function automatic logic [31:0] refAlu(input logic [1:0] aluOp, input logic [2:0] f3,
                                          input logic [6:0] f7, input logic [31:0] a,
                                          input logic [31:0] d2, input logic [31:0] imm,
                                          input logic aluSrc);
        logic [31:0] b;
        logic        alt;
        b   = aluSrc ? imm : d2;
        alt = (aluOp == 2'b10) ? (f7 == 7'b0100000) : imm[10];
        if (aluOp == 2'b00) return a + b;
        if (aluOp == 2'b01) return 32'h0;
        case (f3)
            3'd0: return (aluOp == 2'b10 && alt) ? a - b : a + b;
            3'd1: return a << b[4:0];
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic refBranch(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] refMulDiv(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
        longint            sa, sb, ub;
        logic [63:0]       p;
        logic signed [31:0] sa32, sb32;
        sa   = {{32{a[31]}}, a};
        sb   = {{32{b[31]}}, b};
        ub   = {32'b0, b};
        sa32 = a;
        sb32 = b;
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa32 / sb32);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa32 % sb32);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // One single-cycle instruction through EX, with squash/bubble/branch predicted.
    task automatic runSimple(input string tag, input logic [31:0] pc, input logic [31:0] d1,
                             input logic [31:0] d2, input logic [4:0] rd, input logic [6:0] f7,
                             input logic [2:0] f3, input logic [31:0] imm, input logic [2:0] exc,
                             input logic [2:0] memc, input logic [1:0] wbc);
        logic taken;
        logic drop;
        applyStimulus(pc, d1, d2, rd, f7, f3, imm, exc, memc, wbc);
        taken = !expPrevTaken && memc[2] && refBranch(f3, d1, d2);
        drop  = expPrevTaken || taken || (exc == 0 && memc == 0 && wbc == 0);
        checkOutput({tag, ".busy"}, 32'(exBus.exBusy), 32'd0);
        tick();
        checkOutput({tag, ".taken"}, 32'(exBus.exBranchTaken), 32'(taken));
        if (taken) checkOutput({tag, ".target"}, exBus.exBranchTarget, pc + imm);
        checkOutput({tag, ".result"}, exBus.exmemAluResult,
                    drop ? 32'h0 : refAlu(exc[2:1], f3, f7, d1, d2, imm, exc[0]));
        checkOutput({tag, ".data2"}, exBus.exmemData2, drop ? 32'h0 : d2);
        checkOutput({tag, ".rd"}, 32'(exBus.exmemRd), drop ? 32'h0 : 32'(rd));
        checkOutput({tag, ".func3"}, 32'(exBus.exmemFunc3), drop ? 32'h0 : 32'(f3));
        checkOutput({tag, ".memCtrl"}, 32'(exBus.exmemMemCtrl), drop ? 32'h0 : 32'(memc[1:0]));
        checkOutput({tag, ".wbCtrl"}, 32'(exBus.exmemWbCtrl), drop ? 32'h0 : 32'(wbc));
        expPrevTaken = taken;
    endtask

    // One M-op: 33 stall cycles, then the result lands in EX/MEM at the next edge.
    task automatic runMulDiv(input string tag, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] expected);
        int busyCycles;
        applyStimulus(32'h200, a, b, 5'd9, 7'b0000001, f3, 32'h0, 3'b100, 3'b000, 2'b10);
        busyCycles = 0;
        while (exBus.exBusy && busyCycles < 40) begin
            busyCycles++;
            tick();
        end
        checkOutput({tag, ".busyCycles"}, 32'(busyCycles), 32'd33);
        checkOutput({tag, ".bubbleWhileBusy"}, 32'(exBus.exmemWbCtrl), 32'd0);
        tick();
        checkOutput({tag, ".result"}, exBus.exmemAluResult, expected);
        checkOutput({tag, ".rd"}, 32'(exBus.exmemRd), 32'd9);
        checkOutput({tag, ".wbCtrl"}, 32'(exBus.exmemWbCtrl), 32'd2);
        applyBubble();
        expPrevTaken = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".result"}, exBus.exmemAluResult, 32'h0);
        checkOutput({tag, ".data2"}, exBus.exmemData2, 32'h0);
        checkOutput({tag, ".rd"}, 32'(exBus.exmemRd), 32'h0);
        checkOutput({tag, ".func3"}, 32'(exBus.exmemFunc3), 32'h0);
        checkOutput({tag, ".memCtrl"}, 32'(exBus.exmemMemCtrl), 32'h0);
        checkOutput({tag, ".wbCtrl"}, 32'(exBus.exmemWbCtrl), 32'h0);
        checkOutput({tag, ".taken"}, 32'(exBus.exBranchTaken), 32'h0);
        checkOutput({tag, ".target"}, exBus.exBranchTarget, 32'h0);
        checkOutput({tag, ".busy"}, 32'(exBus.exBusy), 32'h0);
    endtask

    initial begin
        logic [1:0]  aluOp;
        logic [2:0]  f3, memc, exc;
        logic [6:0]  f7;
        logic [31:0] d1, d2, imm, pc, a, b;
        logic [1:0]  wbc;
        logic        aluSrc;

        rst_n        = 1'b0;
        expPrevTaken = 1'b0;
        applyBubble();
        tick();
        tick();
        checkAllZero("reset");
        rst_n = 1'b1;

        runSimple("addR", 32'h0, 32'd5, 32'hFFFF_FFFF, 5'd3, 7'b0000000, 3'd0, 32'h0,
                  3'b100, 3'b000, 2'b10);
        checkOutput("addR.value", exBus.exmemAluResult, 32'd4);
        runSimple("subR", 32'h0, 32'd5, 32'd7, 5'd4, 7'b0100000, 3'd0, 32'h0,
                  3'b100, 3'b000, 2'b10);
        runSimple("srai31", 32'h0, 32'h8000_0000, 32'h0, 5'd5, 7'b0100000, 3'd5, 32'h0000_041F,
                  3'b111, 3'b000, 2'b10);
        checkOutput("srai31.value", exBus.exmemAluResult, 32'hFFFF_FFFF);
        runSimple("lwAddr", 32'h0, 32'h1000, 32'h55, 5'd6, 7'd0, 3'd2, 32'hFFFF_FFFC,
                  3'b001, 3'b010, 2'b11);

        // Taken BEQ; the MUL behind it must be squashed without stalling.
        runSimple("beq", 32'h100, 32'd7, 32'd7, 5'd0, 7'd0, 3'd0, 32'h20,
                  3'b010, 3'b100, 2'b00);
        checkOutput("beq.targetValue", exBus.exBranchTarget, 32'h120);
        applyStimulus(32'h104, 32'd3, 32'd4, 5'd8, 7'b0000001, 3'd0, 32'h0,
                      3'b100, 3'b000, 2'b10);
        checkOutput("squashMul.busy", 32'(exBus.exBusy), 32'd0);
        tick();
        checkOutput("squashMul.taken", 32'(exBus.exBranchTaken), 32'd0);
        checkOutput("squashMul.rd", 32'(exBus.exmemRd), 32'd0);
        checkOutput("squashMul.wbCtrl", 32'(exBus.exmemWbCtrl), 32'd0);
        applyBubble();
        expPrevTaken = 1'b0;

        runMulDiv("mul", 3'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA);
        runMulDiv("mulh", 3'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF);
        runMulDiv("div0", 3'd4, 32'd7, 32'd0, 32'hFFFF_FFFF);
        runMulDiv("rem0", 3'd6, 32'd7, 32'd0, 32'd7);
        runMulDiv("divOvf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        runMulDiv("remOvf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
        runMulDiv("divNeg", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        runMulDiv("remNeg", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        runMulDiv("divu", 3'd5, 32'd100, 32'd7, 32'd14);
        runMulDiv("remu", 3'd7, 32'd100, 32'd7, 32'd2);

        // Reset lands while the divider is ten steps into its iteration.
        applyStimulus(32'h300, 32'd1000, 32'd3, 5'd10, 7'b0000001, 3'd4, 32'h0,
                      3'b100, 3'b000, 2'b10);
        for (int i = 0; i < 11; i++) tick();
        checkOutput("midBusy.busy", 32'(exBus.exBusy), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("resetLow.busy", 32'(exBus.exBusy), 32'd0);
        tick();
        checkAllZero("midReset");
        rst_n = 1'b1;
        runSimple("addAfterReset", 32'h0, 32'd20, 32'd22, 5'd11, 7'd0, 3'd0, 32'h0,
                  3'b100, 3'b000, 2'b10);

        for (int i = 0; i < 80; i++) begin
            aluOp  = 2'($urandom_range(0, 3));
            f3     = 3'($urandom_range(0, 7));
            d1     = $urandom;
            d2     = ($urandom_range(0, 2) == 0) ? d1 : $urandom;
            imm    = 32'($signed(12'($urandom_range(0, 4095))));
            pc     = {$urandom, 2'b00};
            wbc    = 2'($urandom_range(0, 3));
            f7     = 7'($urandom_range(0, 127));
            aluSrc = 1'b0;
            memc   = 3'b000;
            case (aluOp)
                2'b00: begin aluSrc = 1'($urandom_range(0, 1)); memc = {1'b0, 2'($urandom_range(0, 3))}; end
                2'b01: begin memc = {1'($urandom_range(0, 3) != 0), 2'b00}; wbc = 2'b00; end
                2'b10: f7 = ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'b0000000;
                default: aluSrc = 1'b1;
            endcase
            exc = {aluOp, aluSrc};
            if ($urandom_range(0, 9) == 0) begin
                exc  = 3'b000;
                memc = 3'b000;
                wbc  = 2'b00;
            end
            runSimple("rand", pc, d1, d2, 5'($urandom_range(0, 31)), f7, f3, imm, exc, memc, wbc);
        end
        if (expPrevTaken) begin
            applyBubble();
            tick();
            expPrevTaken = 1'b0;
        end

        for (int i = 0; i < 16; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
            if (i % 4 == 1) b = 32'($urandom_range(1, 50));
            runMulDiv("randMd", f3, a, b, refMulDiv(f3, a, b));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
